// File: rtl/fpu_add_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : FPU_p                                                        |
// | Description : Shared float word layout and the issue-tag record used to    |
// |               route adder results back to the requester that issued them.  |
// | Contents    : float_t  - sign/exponent/mantissa, packed MSB to LSB         |
// |               tag_t    - {live, index} record carried beside the adder     |
// |               MAX_REQ_BITS - index width of tag_t (supports 16 requesters) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package FPU_p;

  localparam int MAX_REQ_BITS = 4;

  // Default single-precision geometry; the arbiter itself is width-generic
  // and only relies on the sign/exp/mant packing order shown here.
  localparam int N_EXP_DEF  = 8;
  localparam int N_MANT_DEF = 23;

  typedef struct packed {
    logic                  sign;
    logic [N_EXP_DEF-1:0]  exp;
    logic [N_MANT_DEF-1:0] mant;
  } float_t;

  typedef struct packed {
    logic                    live;
    logic [MAX_REQ_BITS-1:0] index;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/fpu_add_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Purely combinational round-robin grant. Searches upward from |
// |               ptr, wrapping at N-1, and grants the first active request.   |
// | Ports       : req [N]  - request vector                                    |
// |               ptr [PW] - first index to consider                           |
// |               en       - when low no grant is produced                     |
// |               gnt [N]  - one-hot grant (all zero when nothing granted)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      // Visit ptr, ptr+1, ... modulo N; the first hit wins.
      w_idx = PW'((int'(ptr) + i) % N);
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fpu_add_arbiter                                              |
// | Description : Shares one pipelined floating-point adder between N_REQ      |
// |               requesters. One operand pair is issued per cycle; a tag      |
// |               pipeline matched to the adder latency steers each result     |
// |               back to the requester that issued it.                        |
// | Ports       : clk, rst (sync, active-low), en (grant enable)               |
// |               req_valid/req_ready, req_a/req_b  - requester handshake      |
// |               fpu_a/fpu_b/fpu_en, fpu_result    - external adder           |
// |               resp_valid/resp_data              - routed results           |
// |               busy, op_count                    - status                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fpu_add_arbiter
  import FPU_p::*;
#(
  parameter int N_REQ   = 4,
  parameter int n_exp   = 8,
  parameter int n_mant  = 23,
  parameter int FPU_LAT = 2,
  parameter int W       = 1 + n_exp + n_mant
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [W-1:0]       fpu_a,
  output logic [W-1:0]       fpu_b,
  output logic               fpu_en,
  input  logic [W-1:0]       fpu_result,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [W-1:0]       resp_data,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int c_PW = $clog2(N_REQ);

  logic [N_REQ-1:0] w_gnt;
  logic             w_grant;
  logic [c_PW-1:0]  w_gidx;
  logic             w_busy;

  logic [c_PW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]     fpu_a_q, fpu_b_q;
  logic             fpu_en_q;
  tag_t             tag_q [0:FPU_LAT];
  logic [N_REQ-1:0] resp_valid_q;
  logic [W-1:0]     resp_data_q;
  logic [15:0]      op_count_q;

  // Reset also masks the grant so nothing handshakes during the reset cycle.
  rr_arbiter #(
    .N  (N_REQ),
    .PW (c_PW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (en & rst),
    .gnt (w_gnt)
  );

  assign w_grant = |w_gnt;

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gidx = c_PW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (w_grant) begin
      ptr_d = (w_gidx == c_PW'(N_REQ - 1)) ? '0 : w_gidx + c_PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q        <= '0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_en_q     <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      op_count_q   <= '0;
      for (int s = 0; s <= FPU_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      fpu_en_q <= w_grant;
      if (w_grant) begin
        fpu_a_q    <= req_a[W*w_gidx +: W];
        fpu_b_q    <= req_b[W*w_gidx +: W];
        op_count_q <= op_count_q + 16'd1;
      end

      // Stage 0 sits alongside fpu_a/fpu_b; stage FPU_LAT lines up with the
      // cycle in which the adder presents the matching fpu_result.
      tag_q[0].live  <= w_grant;
      tag_q[0].index <= MAX_REQ_BITS'(w_gidx);
      for (int s = 1; s <= FPU_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end

      if (tag_q[FPU_LAT].live) begin
        resp_valid_q <= N_REQ'(1) << tag_q[FPU_LAT].index;
        resp_data_q  <= fpu_result;
      end else begin
        resp_valid_q <= '0;
      end
    end
  end

  always_comb begin
    w_busy = fpu_en_q;
    for (int s = 0; s <= FPU_LAT; s++) begin
      w_busy = w_busy | tag_q[s].live;
    end
  end

  assign req_ready  = w_gnt;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_en     = fpu_en_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = w_busy;
  assign op_count   = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fpu_add_arbiter                                           |
// | Description : Directed self-checking bench for fpu_add_arbiter with a      |
// |               two-stage single-precision adder model on the FPU port.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fpu_add_arbiter;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int FPU_LAT = 2;

  logic           clk;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   fpu_a;
  logic [W-1:0]   fpu_b;
  logic           fpu_en;
  logic [W-1:0]   fpu_result;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           busy;
  logic [15:0]    op_count;

  int n_cmp = 0;
  int n_err = 0;

  fpu_add_arbiter #(
    .N_REQ   (N),
    .n_exp   (8),
    .n_mant  (23),
    .FPU_LAT (FPU_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_en     (fpu_en),
    .fpu_result (fpu_result),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- adder model (normal numbers / zero only) ----------------
  function automatic logic [63:0] s2d(input logic [31:0] x);
    if (x[30:23] == 8'd0) return {x[31], 63'd0};
    return {x[31], (11'(x[30:23]) + 11'd896), x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    return d2s($realtobits(ra + rb));
  endfunction

  logic [W-1:0] add_pipe [FPU_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= fadd(fpu_a, fpu_b);
    for (int j = 1; j < FPU_LAT; j++) add_pipe[j] <= add_pipe[j-1];
  end
  assign fpu_result = add_pipe[FPU_LAT-1];

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[W*i +: W] = a;
    req_b[W*i +: W] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; en = 1'b1; req_valid = 4'hF;
    set_op(0, 32'h3F800000, 32'h3F800000);
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_cmp++; if (fpu_en !== 1'b0) begin n_err++; $display("FAIL reset_fpu_en: got %b expected 0", fpu_en); end
    n_cmp++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0) begin n_err++; $display("FAIL reset_fpu_ab: got %h/%h expected 0/0", fpu_a, fpu_b); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (op_count !== 16'h0) begin n_err++; $display("FAIL reset_op_count: got %h expected 0000", op_count); end
    n_cmp++; if (resp_valid !== 4'b0 || resp_data !== 32'h0) begin n_err++; $display("FAIL reset_resp: got %b/%h expected 0000/0", resp_valid, resp_data); end
    req_valid = '0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [N-1:0] er;
    do_reset();
    for (int t = 0; t <= 5; t++) begin
      @(negedge clk);
      if (t == 0) begin
        req_valid = 4'b0100;
        set_op(2, 32'h3F800000, 32'h40000000);
      end else begin
        req_valid = '0;
      end
      #1;
      er = (t == 0) ? 4'b0100 : 4'b0000;
      n_cmp++; if (req_ready !== er) begin n_err++; $display("FAIL single_ready t=%0d: got %b expected %b", t, req_ready, er); end
      n_cmp++; if (fpu_en !== (t == 1)) begin n_err++; $display("FAIL single_fpu_en t=%0d: got %b expected %b", t, fpu_en, (t == 1)); end
      if (t == 1) begin
        n_cmp++; if (fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000) begin n_err++; $display("FAIL single_fpu_ab: got %h/%h expected 3f800000/40000000", fpu_a, fpu_b); end
      end
      er = (t == 4) ? 4'b0100 : 4'b0000;
      n_cmp++; if (resp_valid !== er) begin n_err++; $display("FAIL single_resp_valid t=%0d: got %b expected %b", t, resp_valid, er); end
      if (t == 4) begin
        n_cmp++; if (resp_data !== 32'h40400000) begin n_err++; $display("FAIL single_resp_data: got %h expected 40400000", resp_data); end
        n_cmp++; if (op_count !== 16'd1) begin n_err++; $display("FAIL single_op_count: got %h expected 0001", op_count); end
      end
      n_cmp++; if (busy !== (t >= 1 && t <= 3)) begin n_err++; $display("FAIL single_busy t=%0d: got %b expected %b", t, busy, (t >= 1 && t <= 3)); end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0]  sums [4];
    logic [N-1:0] er;
    sums[0] = 32'h40000000; sums[1] = 32'h40C00000;
    sums[2] = 32'h3FC00000; sums[3] = 32'h41000000;
    do_reset();
    set_op(0, 32'h3F800000, 32'h3F800000);  // 1+1 = 2
    set_op(1, 32'h40000000, 32'h40800000);  // 2+4 = 6
    set_op(2, 32'h3F000000, 32'h3F800000);  // 0.5+1 = 1.5
    set_op(3, 32'h40400000, 32'h40A00000);  // 3+5 = 8
    for (int t = 0; t <= 13; t++) begin
      @(negedge clk);
      req_valid = (t < 8) ? 4'hF : 4'h0;
      #1;
      er = (t < 8) ? 4'(1 << (t % 4)) : 4'b0000;
      n_cmp++; if (req_ready !== er) begin n_err++; $display("FAIL rr_ready t=%0d: got %b expected %b", t, req_ready, er); end
      er = (t >= 4 && t < 12) ? 4'(1 << ((t - 4) % 4)) : 4'b0000;
      n_cmp++; if (resp_valid !== er) begin n_err++; $display("FAIL rr_resp_valid t=%0d: got %b expected %b", t, resp_valid, er); end
      if (t >= 4 && t < 12) begin
        n_cmp++; if (resp_data !== sums[(t - 4) % 4]) begin n_err++; $display("FAIL rr_resp_data t=%0d: got %h expected %h", t, resp_data, sums[(t - 4) % 4]); end
      end
    end
    n_cmp++; if (op_count !== 16'd8) begin n_err++; $display("FAIL rr_op_count: got %h expected 0008", op_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  vals [5];
    logic [31:0]  sums [5];
    logic [N-1:0] er;
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000;
    vals[3] = 32'h40800000; vals[4] = 32'h40A00000;
    sums[0] = 32'h40000000; sums[1] = 32'h40800000; sums[2] = 32'h40C00000;
    sums[3] = 32'h41000000; sums[4] = 32'h41200000;
    do_reset();
    for (int t = 0; t <= 9; t++) begin
      @(negedge clk);
      if (t < 5) begin
        req_valid = 4'b0010;
        set_op(1, vals[t], vals[t]);
      end else begin
        req_valid = '0;
      end
      #1;
      er = (t < 5) ? 4'b0010 : 4'b0000;
      n_cmp++; if (req_ready !== er) begin n_err++; $display("FAIL b2b_ready t=%0d: got %b expected %b", t, req_ready, er); end
      er = (t >= 4 && t <= 8) ? 4'b0010 : 4'b0000;
      n_cmp++; if (resp_valid !== er) begin n_err++; $display("FAIL b2b_resp_valid t=%0d: got %b expected %b", t, resp_valid, er); end
      if (t >= 4 && t <= 8) begin
        n_cmp++; if (resp_data !== sums[t - 4]) begin n_err++; $display("FAIL b2b_resp_data t=%0d: got %h expected %h", t, resp_data, sums[t - 4]); end
      end
    end
  endtask

  task automatic test_en_pause();
    logic [N-1:0] er;
    logic [31:0]  ed;
    do_reset();
    for (int t = 0; t <= 10; t++) begin
      @(negedge clk);
      if (t == 0) begin
        en = 1'b1; req_valid = 4'b0100;
        set_op(2, 32'h3F000000, 32'h3F000000);  // 0.5+0.5 = 1
      end else if (t <= 3) begin
        en = 1'b0; req_valid = 4'b1001;
        set_op(0, 32'h3F800000, 32'h40000000);  // 1+2 = 3
        set_op(3, 32'h40800000, 32'h40800000);  // 4+4 = 8
      end else if (t == 4) begin
        en = 1'b1; req_valid = 4'b1001;
      end else if (t == 5) begin
        req_valid = 4'b0001;
      end else begin
        req_valid = '0;
      end
      #1;
      case (t)
        0:       er = 4'b0100;
        4:       er = 4'b1000;
        5:       er = 4'b0001;
        default: er = 4'b0000;
      endcase
      n_cmp++; if (req_ready !== er) begin n_err++; $display("FAIL en_ready t=%0d: got %b expected %b", t, req_ready, er); end
      case (t)
        4:       begin er = 4'b0100; ed = 32'h3F800000; end
        8:       begin er = 4'b1000; ed = 32'h41000000; end
        9:       begin er = 4'b0001; ed = 32'h40400000; end
        default: begin er = 4'b0000; ed = 32'h0; end
      endcase
      n_cmp++; if (resp_valid !== er) begin n_err++; $display("FAIL en_resp_valid t=%0d: got %b expected %b", t, resp_valid, er); end
      if (er != 4'b0000) begin
        n_cmp++; if (resp_data !== ed) begin n_err++; $display("FAIL en_resp_data t=%0d: got %h expected %h", t, resp_data, ed); end
      end
      if (t == 2) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL en_busy: got %b expected 1", busy); end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] er;
    do_reset();
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(1, 32'h40000000, 32'h40000000);
    set_op(2, 32'h40400000, 32'h40400000);
    set_op(3, 32'h40800000, 32'h40800000);
    for (int t = 0; t <= 8; t++) begin
      @(negedge clk);
      if (t <= 2) begin
        req_valid = 4'b0111;
      end else if (t == 3) begin
        rst = 1'b0; req_valid = 4'b0111;
      end else if (t == 4) begin
        rst = 1'b1; req_valid = '0;
      end else if (t == 5) begin
        req_valid = 4'b1110;
      end else begin
        req_valid = '0;
      end
      #1;
      if (t <= 2)      er = 4'(1 << t);
      else if (t == 5) er = 4'b0010;
      else             er = 4'b0000;
      n_cmp++; if (req_ready !== er) begin n_err++; $display("FAIL midrst_ready t=%0d: got %b expected %b", t, req_ready, er); end
      n_cmp++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL midrst_resp_valid t=%0d: got %b expected 0000", t, resp_valid); end
      if (t == 4) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++; if (op_count !== 16'd0) begin n_err++; $display("FAIL midrst_op_count: got %h expected 0000", op_count); end
        n_cmp++; if (fpu_en !== 1'b0) begin n_err++; $display("FAIL midrst_fpu_en: got %b expected 0", fpu_en); end
      end
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    set_op(0, 32'h3F800000, 32'h3F800000);
    for (int t = 0; t <= 65537; t++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      if (t >= 65534) begin
        n_cmp++; if (op_count !== 16'(t)) begin n_err++; $display("FAIL wrap_op_count t=%0d: got %h expected %h", t, op_count, 16'(t)); end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_en_pause();
    test_reset_midop();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
